pc_gen: RTL and testbench

Parametrised fetch program-counter generator: successor to the single-register PC. Holds the fetch PC and advances it by a configurable instruction size. Supports pipeline stall, branch/exception redirect, and a circular return-address stack (RAS) for return prediction. Sits at the head of the fetch stage. Drives instruction-memory address and the IF/ID pipeline register; takes control from decode (push/pop) and execute (redirect, stall).

---
 rtl/pc_gen.sv | 106 ++++++++++
 tb/tb_pc_gen.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential advance, stall, redirect and a
// circular return-address stack for return prediction.
module pc_gen #(
    parameter int unsigned            PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0,
    parameter int unsigned            INSTR_BYTES  = 4,
    parameter int unsigned            RAS_DEPTH    = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 stall_i,
    input  logic                                 redirect_valid_i,
    input  logic [PC_WIDTH-1:0]                  redirect_pc_i,
    input  logic                                 ras_push_i,
    input  logic [PC_WIDTH-1:0]                  ras_push_addr_i,
    input  logic                                 ras_pop_i,
    output logic [PC_WIDTH-1:0]                  pc_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0]       ras_count_o,
    output logic                                 ras_empty_o,
    output logic                                 ras_full_o
);

    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(INSTR_BYTES) - PC_WIDTH'(1));
    localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]    top_q, top_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PC_WIDTH-1:0] ras_d [RAS_DEPTH];

    logic                pop_eff;
    logic [PTR_W-1:0]    push_idx;
    logic [PC_WIDTH-1:0] push_addr;

    // Next-PC selection and stack update; a pop only counts when it steers the PC.
    always_comb begin
        pc_d      = pc_q;
        top_d     = top_q;
        count_d   = count_q;
        ras_d     = ras_q;
        pop_eff   = ras_pop_i && !stall_i && !redirect_valid_i && (count_q != '0);
        push_addr = ras_push_addr_i & ALIGN_MASK;
        push_idx  = pop_eff ? top_q : PTR_W'(top_q + PTR_W'(1));

        if (redirect_valid_i) begin
            pc_d = redirect_pc_i & ALIGN_MASK;
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (pop_eff) begin
            pc_d = ras_q[top_q];
        end else begin
            pc_d = PC_WIDTH'(pc_q + PC_WIDTH'(INSTR_BYTES));
        end

        // Push with a same-cycle pop replaces the slot just consumed.
        if (ras_push_i) begin
            ras_d[push_idx] = push_addr;
            if (!pop_eff) begin
                top_d = push_idx;
                if (count_q != CNT_MAX) begin
                    count_d = CNT_W'(count_q + CNT_W'(1));
                end
            end
        end else if (pop_eff) begin
            top_d   = PTR_W'(top_q - PTR_W'(1));
            count_d = CNT_W'(count_q - CNT_W'(1));
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_MAX);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= RESET_VECTOR;
            top_q   <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            top_q   <= top_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    // Entry storage carries no reset; contents are only read while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ras_q <= ras_d;
        end
    end

    assign pc_o        = pc_q;
    assign ras_count_o = count_q;
    assign ras_empty_o = empty_q;
    assign ras_full_o  = full_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random traffic
// checked against a queue-based return-stack model.
module tb_pc_gen;

    localparam int unsigned PCW   = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV    = 32'h100;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        ras_push_i = 1'b0;
    logic [31:0] ras_push_addr_i = '0;
    logic        ras_pop_i = 1'b0;
    logic [31:0] pc_o;
    logic [2:0]  ras_count_o;
    logic        ras_empty_o;
    logic        ras_full_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] mdl_pc;
    logic [31:0] mdl_q [$];

    pc_gen #(
        .PC_WIDTH    (PCW),
        .RESET_VECTOR(RV),
        .INSTR_BYTES (4),
        .RAS_DEPTH   (DEPTH)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .ras_push_i      (ras_push_i),
        .ras_push_addr_i (ras_push_addr_i),
        .ras_pop_i       (ras_pop_i),
        .pc_o            (pc_o),
        .ras_count_o     (ras_count_o),
        .ras_empty_o     (ras_empty_o),
        .ras_full_o      (ras_full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive(input logic rst, input logic stall, input logic redir,
                         input logic [31:0] rpc, input logic push,
                         input logic [31:0] paddr, input logic pop);
        rst_i = rst; stall_i = stall; redirect_valid_i = redir; redirect_pc_i = rpc;
        ras_push_i = push; ras_push_addr_i = paddr; ras_pop_i = pop;
    endtask

    // One clock: the model absorbs the inputs presented at the edge, outputs are sampled 1ns later.
    task automatic tick();
        logic pop_ok;
        logic [31:0] a;
        @(posedge clk_i);
        if (rst_i) begin
            mdl_pc = RV;
            mdl_q.delete();
        end else begin
            pop_ok = ras_pop_i && !redirect_valid_i && !stall_i && (mdl_q.size() > 0);
            if (redirect_valid_i)  mdl_pc = redirect_pc_i & 32'hFFFF_FFFC;
            else if (stall_i)      mdl_pc = mdl_pc;
            else if (pop_ok)       mdl_pc = mdl_q[$];
            else                   mdl_pc = mdl_pc + 32'd4;
            a = ras_push_addr_i & 32'hFFFF_FFFC;
            if (ras_push_i) begin
                if (pop_ok) begin
                    mdl_q[mdl_q.size() - 1] = a;
                end else begin
                    if (mdl_q.size() == DEPTH) void'(mdl_q.pop_front());
                    mdl_q.push_back(a);
                end
            end else if (pop_ok) begin
                void'(mdl_q.pop_back());
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (pc_o !== 32'h100 || ras_count_o !== 3'd0 || ras_empty_o !== 1'b1 || ras_full_o !== 1'b0) begin
                failures++;
                $display("FAIL reset: pc_o=%h count=%0d empty=%b full=%b expected pc 00000100 count 0 empty 1 full 0",
                         pc_o, ras_count_o, ras_empty_o, ras_full_o);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (pc_o !== 32'h100 + 32'(4 * i) || ras_empty_o !== 1'b1) begin
                failures++;
                $display("FAIL sequential: pc_o=%h empty=%b expected pc %h empty 1", pc_o, ras_empty_o, 32'h100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall_redirect();
        drive(0, 0, 1, 32'h20, 0, 0, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc_o !== 32'h20) begin
            failures++;
            $display("FAIL stall_hold: pc_o=%h expected 00000020", pc_o);
        end
        drive(0, 1, 1, 32'h403, 0, 0, 0);
        tick();
        checks++;
        if (pc_o !== 32'h400) begin
            failures++;
            $display("FAIL stall_redirect: pc_o=%h expected 00000400", pc_o);
        end
    endtask

    task automatic test_push_pop();
        logic [31:0] exp_pc [3] = '{32'h2000, 32'h1000, 32'h1004};
        logic [2:0]  exp_cnt[3] = '{3'd1, 3'd0, 3'd0};
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 32'h48, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 32'h1000, 0);
        tick();
        drive(0, 0, 0, 0, 1, 32'h2000, 0);
        tick();
        checks++;
        if (pc_o !== 32'h50 || ras_count_o !== 3'd2) begin
            failures++;
            $display("FAIL push_two: pc_o=%h count=%0d expected pc 00000050 count 2", pc_o, ras_count_o);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc_o !== exp_pc[i] || ras_count_o !== exp_cnt[i] || ras_empty_o !== (exp_cnt[i] == 3'd0)) begin
                failures++;
                $display("FAIL pop_%0d: pc_o=%h count=%0d empty=%b expected pc %h count %0d",
                         i, pc_o, ras_count_o, ras_empty_o, exp_pc[i], exp_cnt[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_pc [4] = '{32'hE0, 32'hD0, 32'hC0, 32'hB0};
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, 32'hA0 + 32'(16 * i), 0);
            tick();
            if (i >= 3) begin
                checks++;
                if (ras_full_o !== 1'b1 || ras_count_o !== 3'd4) begin
                    failures++;
                    $display("FAIL full_after_push%0d: full=%b count=%0d expected full 1 count 4", i + 1, ras_full_o, ras_count_o);
                end
            end
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (pc_o !== exp_pc[i] || ras_count_o !== 3'(3 - i)) begin
                failures++;
                $display("FAIL wrap_pop_%0d: pc_o=%h count=%0d expected pc %h count %0d", i, pc_o, ras_count_o, exp_pc[i], 3 - i);
            end
        end
        checks++;
        if (ras_empty_o !== 1'b1 || ras_full_o !== 1'b0) begin
            failures++;
            $display("FAIL wrap_empty: empty=%b full=%b expected empty 1 full 0", ras_empty_o, ras_full_o);
        end
    endtask

    task automatic test_push_pop_same();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 32'h200, 0);
        tick();
        drive(0, 0, 0, 0, 1, 32'h300, 0);
        tick();
        drive(0, 0, 0, 0, 1, 32'h700, 1);
        tick();
        checks++;
        if (pc_o !== 32'h300 || ras_count_o !== 3'd2) begin
            failures++;
            $display("FAIL push_pop_same: pc_o=%h count=%0d expected pc 00000300 count 2", pc_o, ras_count_o);
        end
        drive(0, 1, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if (pc_o !== 32'h300 || ras_count_o !== 3'd2) begin
            failures++;
            $display("FAIL stall_pop: pc_o=%h count=%0d expected pc 00000300 count 2", pc_o, ras_count_o);
        end
        drive(0, 0, 1, 32'h900, 0, 0, 1);
        tick();
        checks++;
        if (pc_o !== 32'h900 || ras_count_o !== 3'd2) begin
            failures++;
            $display("FAIL redirect_pop: pc_o=%h count=%0d expected pc 00000900 count 2", pc_o, ras_count_o);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if (pc_o !== 32'h700 || ras_count_o !== 3'd1) begin
            failures++;
            $display("FAIL pop_replaced: pc_o=%h count=%0d expected pc 00000700 count 1", pc_o, ras_count_o);
        end
    endtask

    task automatic test_wrap_reset();
        drive(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h5550, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        checks++;
        if (pc_o !== 32'h0) begin
            failures++;
            $display("FAIL pc_wrap: pc_o=%h expected 00000000", pc_o);
        end
        drive(1, 0, 1, 32'h80, 1, 32'h6660, 1);
        tick();
        checks++;
        if (pc_o !== RV || ras_count_o !== 3'd0 || ras_empty_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: pc_o=%h count=%0d empty=%b expected pc 00000100 count 0 empty 1", pc_o, ras_count_o, ras_empty_o);
        end
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        checks++;
        if (pc_o !== 32'h104 || ras_count_o !== 3'd0) begin
            failures++;
            $display("FAIL after_reset: pc_o=%h count=%0d expected pc 00000104 count 0", pc_o, ras_count_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 40) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0, $urandom,
                  ($urandom % 3) == 0, $urandom, ($urandom % 3) != 0);
            tick();
            checks++;
            if (pc_o !== mdl_pc || ras_count_o !== 3'(mdl_q.size()) ||
                ras_empty_o !== (mdl_q.size() == 0) || ras_full_o !== (mdl_q.size() == DEPTH)) begin
                failures++;
                $display("FAIL random_%0d: pc_o=%h count=%0d empty=%b full=%b expected pc %h count %0d",
                         i, pc_o, ras_count_o, ras_empty_o, ras_full_o, mdl_pc, mdl_q.size());
            end
        end
    endtask

    initial begin
        mdl_pc = RV;
        test_reset();
        test_stall_redirect();
        test_push_pop();
        test_overflow();
        test_push_pop_same();
        test_wrap_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
